eight_bit_shift_add_multiplier_module: RTL
==========================================

# eight_bit_shift_add_multiplier_module

Sequential 8x8 unsigned multiplier controller that sits directly upstream and downstream of the 8-bit ripple-carry adder `eight_bit_full_adder_module`. It drives the adder's `a`, `b` and `cin` inputs and registers the adder's `sum` and `cout` outputs. The adder is instantiated beside this block at the parent level, not inside it. The block computes a 16-bit product in one add-and-shift step per multiplier bit and reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- none: widths are fixed at 8-bit operands and a 16-bit product to match the adder.

Ports:
- `clk`  in  1  single clock for the block; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `a`  in  8  multiplicand; captured when `start` is accepted.
- `b`  in  8  multiplier; captured when `start` is accepted.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when `product` becomes valid.
- `product`  out  16  result; holds its value until the next accepted `start`.
- `add_a`  out  8  to adder `a`.
- `add_b`  out  8  to adder `b`.
- `add_cin`  out  1  to adder `cin`; tied to 0.
- `add_sum`  in  8  from adder `sum`.
- `add_cout`  in  1  from adder `cout`.

## Operation
Internal registers:
- `mcand[7:0]`: multiplicand.
- `acc[7:0]`: high half of the partial product.
- `mq[7:0]`: multiplier, becoming the low half of the product.
- `cnt[2:0]`: step counter.
- `state`: one of IDLE, RUN, DONE.

Adder drive (combinational):
- `add_a = acc`.
- `add_b = (state==RUN && mq[0]) ? mcand : 8'h00`.
- `add_cin = 0`.

State machine:
- **IDLE:** if `start`, load `mcand<=a`, `mq<=b`, `acc<=0`, `cnt<=0`, then go to RUN. Otherwise hold all registers.
- **RUN:** each edge, load `{acc,mq} <= {add_cout, add_sum, mq[7:1]}` (a right shift of the 17-bit sum) and increment `cnt`. When `cnt==7`, go to DONE.
- **DONE:** go to IDLE; no register update.

Output rules:
- `product = {acc,mq}` at all times.
- `done` is registered; it is set on the edge entering DONE and cleared on the next edge.

Arithmetic:
- Unsigned only.
- Per step, the 9-bit adder result `{add_cout, add_sum}` is the shifted-in value; no overflow is possible, since 255*255 fits in 16 bits.

Boundary rules:
- `start` is ignored in RUN and DONE; it is never queued.
- `start` held high continuously causes a new operation to be accepted in the first IDLE cycle after DONE.
- Operand values have no effect on latency; a zero operand still takes 8 RUN cycles.
- `a` and `b` may change freely after acceptance.

## Timing
Reset values (asynchronous, while `rst_n=0`):
- state=IDLE.
- `busy=0`, `done=0`, `product=16'h0000`.
- `add_a=0`, `add_b=0`, `add_cin=0`.
- `cnt=0`, `mcand=0`.

Latency, with `start` accepted on edge E0:
- `busy` rises after E0.
- RUN occupies edges E1..E8.
- `done=1` and the final `product` are visible after E8.
- State returns to IDLE and `busy` and `done` fall after E9.
- Earliest next acceptance is at E10. Throughput is one product per 10 cycles.

Combinational path:
- The adder is purely combinational between `add_a`/`add_b` and `add_sum`/`add_cout`. One 8-bit ripple delay plus the mux must fit in one clock period.

Reset mid-operation:
- Asserting `rst_n` low at any point aborts immediately: state returns to IDLE and all outputs go to their reset values.
- No `done` pulse is produced for the aborted operation.
- After `rst_n` rises, the first edge behaves as IDLE.

## Test plan
- a=13, b=11, single `start` pulse -> `busy` high for 9 cycles; `done` for exactly 1 cycle after E8; `product=16'h008F` (143), held afterwards.
- a=255, b=255 -> `product=16'hFE01` (65025); check `add_cout=1` is captured on the steps where it occurs.
- a=0, b=200 and a=200, b=0 -> `product=0`, same 8-cycle latency; `add_b=0` on every RUN cycle where `mq[0]=0`.
- Pulse `start` again at E3 and at E8 (DONE) with a=1, b=1 -> ignored; the first result is unchanged and no second `done`. `start` held high continuously -> operations accepted at E0, E10, E20.
- Reset: drop `rst_n` between E4 and E5 -> `busy`, `done` and `product` go to 0 immediately with no `done` pulse. After release, a=7, b=6 completes with `product=16'h002A`.
- Per-cycle check of `add_a`, `add_b` and `add_cin` against a reference model over 1000 random operand pairs; every `product` equals a*b.

Source files
------------

// File: rtl/eight_bit_shift_add_multiplier_module.sv
// Sequential 8x8 unsigned shift-and-add multiplier controller. It drives an
// external 8-bit adder and registers its 9-bit result, one step per multiplier bit.
module eight_bit_shift_add_multiplier_module (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_cin,
  input  logic [7:0]  add_sum,
  input  logic        add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  acc_q,   acc_d;
  logic [7:0]  mq_q,    mq_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic        done_q,  done_d;

  // The adder only ever sees the multiplicand while stepping on a set multiplier bit.
  assign add_a   = acc_q;
  assign add_b   = (state_q == RUN && mq_q[0]) ? mcand_q : 8'h00;
  assign add_cin = 1'b0;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = {acc_q, mq_q};

  always_comb begin
    // NOTE: every next-state signal gets a hold/default value before the case so
    // no branch leaves one unassigned, which would infer a latch.
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = 8'h00;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Right shift of the 17-bit {cout, sum, mq}; the carry becomes acc[7].
        {acc_d, mq_d} = {add_cout, add_sum, mq_q[7:1]};
        cnt_d         = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= 8'h00;
      acc_q   <= 8'h00;
      mq_q    <= 8'h00;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule
